// File: rtl/snn_neuron_bank.sv
// snn_neuron_bank: per-neuron membrane accumulators with a sequential
// threshold/leak evaluation pass at the end of each timestep.

// One membrane register: saturating accumulate, or residue write-back.
module snn_neuron_cell #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] psum,
  input  logic             wb_en,
  input  logic [WIDTH-1:0] wb_val,
  output logic [WIDTH-1:0] mem
);
  logic [WIDTH:0] sum;

  assign sum = {1'b0, mem} + {1'b0, psum};

  // accumulate (clamped at all-ones) during ACCUM, take residue during EVAL
  always_ff @(posedge clk) begin
    if (reset)       mem <= '0;
    else if (acc_en) mem <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    else if (wb_en)  mem <= wb_val;
  end
endmodule

module snn_neuron_bank #(
  parameter int WIDTH       = 8,
  parameter int NUM_NEURONS = 4,
  parameter int THRESHOLD   = 64,
  parameter int LEAK        = 0,
  parameter int RESET_MODE  = 0,
  parameter int TS_WIDTH    = 4,
  localparam int IDW        = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IDW-1:0]      in_id,
  input  logic [WIDTH-1:0]    in_psum,
  input  logic                in_eot,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IDW-1:0]      out_id,
  output logic                out_spike,
  output logic [WIDTH-1:0]    out_residue,
  output logic [TS_WIDTH-1:0] out_ts,
  output logic                err
);
  localparam logic [WIDTH-1:0] THR    = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] LK     = WIDTH'(LEAK);
  // one extra bit so the range check is meaningful for power-of-two banks
  localparam logic [IDW:0]     NN_EXT = (IDW+1)'(NUM_NEURONS);
  localparam logic [IDW-1:0]   LAST   = IDW'(NUM_NEURONS - 1);

  typedef enum logic {ACCUM, EVAL} state_t;

  state_t                            state;
  logic [IDW-1:0]                    idx;
  logic [TS_WIDTH-1:0]               ts;
  logic [NUM_NEURONS-1:0][WIDTH-1:0] mem;
  logic [WIDTH-1:0]                  mem_sel;
  logic [WIDTH-1:0]                  residue;
  logic                              fire;
  logic                              in_hs;
  logic                              out_hs;
  logic                              id_ok;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == EVAL);
  assign out_id    = idx;
  assign out_ts    = ts;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;
  assign id_ok  = {1'b0, in_id} < NN_EXT;

  assign mem_sel = mem[idx];
  assign fire    = (mem_sel >= THR);

  // residue: subtract/zero on fire, otherwise leak with a floor at zero
  always_comb begin
    residue = '0;
    if (fire)             residue = (RESET_MODE != 0) ? '0 : mem_sel - THR;
    else if (mem_sel > LK) residue = mem_sel - LK;
  end

  // results are masked outside EVAL so idle outputs read as zero
  assign out_spike   = out_valid & fire;
  assign out_residue = out_valid ? residue : '0;

  genvar g;
  generate
    for (g = 0; g < NUM_NEURONS; g++) begin : g_cell
      snn_neuron_cell #(.WIDTH(WIDTH)) u_cell (
        .clk    (clk),
        .reset  (reset),
        .acc_en (in_hs & id_ok & (in_id == IDW'(g))),
        .psum   (in_psum),
        .wb_en  (out_hs & (idx == IDW'(g))),
        .wb_val (residue),
        .mem    (mem[g])
      );
    end
  endgenerate

  // control: accumulate until eot, then walk idx through every neuron
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      idx   <= '0;
      ts    <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (in_hs) begin
          if (!id_ok) err <= 1'b1;
          if (in_eot) begin
            idx   <= '0;
            state <= EVAL;
          end
        end
        EVAL: if (out_hs) begin
          if (idx == LAST) begin
            idx   <= '0;
            ts    <= ts + TS_WIDTH'(1);
            state <= ACCUM;
          end else begin
            idx <= idx + IDW'(1);
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end
endmodule

// File: tb/tb_snn_neuron_bank.sv
// Bench for snn_neuron_bank: three banks (subtract mode, reset-to-zero mode,
// 3-neuron bank) driven by directed steps; a scoreboard holds expected beats.
module tb_snn_neuron_bank;
  typedef struct packed {
    logic [1:0] id;
    logic       spike;
    logic [7:0] res;
    logic [3:0] ts;
  } beat_t;

  logic       clk;
  logic [2:0] rst, in_valid, in_ready, in_eot, out_valid, out_ready, out_spike, err;
  logic [1:0] in_id [3];
  logic [1:0] out_id [3];
  logic [7:0] in_psum [3];
  logic [7:0] out_residue [3];
  logic [3:0] out_ts [3];

  beat_t sb [3][$];
  int    m [3][4];
  int    tsm [3];
  int    nn [3]   = '{4, 4, 3};
  int    mode [3] = '{0, 1, 0};
  int    leak     = 2;
  int    n_cmp    = 0;
  int    n_err    = 0;

  snn_neuron_bank #(.WIDTH(8), .NUM_NEURONS(4), .THRESHOLD(64), .LEAK(2), .RESET_MODE(0), .TS_WIDTH(4)) u_a (
    .clk(clk), .reset(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_id(in_id[0]),
    .in_psum(in_psum[0]), .in_eot(in_eot[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_id(out_id[0]), .out_spike(out_spike[0]), .out_residue(out_residue[0]), .out_ts(out_ts[0]), .err(err[0]));

  snn_neuron_bank #(.WIDTH(8), .NUM_NEURONS(4), .THRESHOLD(64), .LEAK(2), .RESET_MODE(1), .TS_WIDTH(4)) u_b (
    .clk(clk), .reset(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_id(in_id[1]),
    .in_psum(in_psum[1]), .in_eot(in_eot[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_id(out_id[1]), .out_spike(out_spike[1]), .out_residue(out_residue[1]), .out_ts(out_ts[1]), .err(err[1]));

  snn_neuron_bank #(.WIDTH(8), .NUM_NEURONS(3), .THRESHOLD(64), .LEAK(2), .RESET_MODE(0), .TS_WIDTH(4)) u_c (
    .clk(clk), .reset(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_id(in_id[2]),
    .in_psum(in_psum[2]), .in_eot(in_eot[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_id(out_id[2]), .out_spike(out_spike[2]), .out_residue(out_residue[2]), .out_ts(out_ts[2]), .err(err[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cur(input int d);
    beat_t b;
    b.id = out_id[d]; b.spike = out_spike[d]; b.res = out_residue[d]; b.ts = out_ts[d];
    return 32'(b);
  endfunction

  // model of one evaluation pass: queues every expected result beat
  task automatic model_eval(input int d);
    beat_t b;
    for (int i = 0; i < nn[d]; i++) begin
      int v, r;
      bit s;
      v = m[d][i];
      s = (v >= 64);
      if (s) r = (mode[d] != 0) ? 0 : v - 64;
      else   r = (v > leak) ? v - leak : 0;
      m[d][i] = r;
      b.id = 2'(i); b.spike = s; b.res = 8'(r); b.ts = 4'(tsm[d]);
      sb[d].push_back(b);
    end
    tsm[d] = (tsm[d] + 1) % 16;
  endtask

  // one input beat; returns one cycle (+1) after its handshake edge
  task automatic beat(input int d, input int id, input int psum, input bit eot);
    in_valid[d] = 1'b1; in_id[d] = 2'(id); in_psum[d] = 8'(psum); in_eot[d] = eot;
    if (id < nn[d]) m[d][id] = (m[d][id] + psum > 255) ? 255 : m[d][id] + psum;
    if (eot) model_eval(d);
    @(posedge clk); #1;
    in_valid[d] = 1'b0; in_eot[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d);
    bit done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      if (in_ready[d] && sb[d].size() == 0) done = 1;
    end
    chk($sformatf("idle%0d", d), 32'(done), 1);
  endtask

  // scoreboard check on every output handshake
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst[d] && out_valid[d] === 1'b1 && out_ready[d]) begin
        chk($sformatf("beat_expected%0d", d), 32'(sb[d].size() != 0), 1);
        if (sb[d].size() != 0) chk($sformatf("beat%0d", d), cur(d), 32'(sb[d].pop_front()));
      end
    end
  end

  initial begin
    beat_t e;
    rst = 3'b111; in_valid = '0; in_eot = '0; out_ready = 3'b111;
    for (int d = 0; d < 3; d++) begin
      in_id[d] = '0; in_psum[d] = '0; tsm[d] = 0;
      for (int i = 0; i < 4; i++) m[d][i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 3'b000;

    // reset state
    chk("rst_in_ready", 32'(in_ready[0]), 1);
    chk("rst_out_valid", 32'(out_valid[0]), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_beat", cur(0), 0);

    // fire/subtract, with latency and blocking window
    beat(0, 0, 40, 0);
    beat(0, 0, 30, 1);
    chk("eval_latency", 32'(out_valid[0]), 1);
    chk("eval_in_ready", 32'(in_ready[0]), 0);
    repeat (3) @(posedge clk);
    #1 chk("block_window", 32'(in_ready[0]), 0);
    @(posedge clk); #1;
    chk("ready_back", 32'(in_ready[0]), 1);
    chk("ts_after", 32'(out_ts[0]), 1);

    // saturation
    beat(0, 1, 200, 0);
    beat(0, 1, 100, 0);
    beat(0, 3, 0, 1);
    wait_idle(0);

    // leak, repeated until floored at zero
    beat(0, 2, 10, 1);
    wait_idle(0);
    for (int k = 0; k < 4; k++) begin
      beat(0, 0, 0, 1);
      wait_idle(0);
    end

    // backpressure: five stalled cycles must hold the head result
    out_ready[0] = 1'b0;
    beat(0, 1, 70, 1);
    for (int k = 0; k < 5; k++) begin
      e = sb[0][0];
      chk("stall_valid", 32'(out_valid[0]), 1);
      chk("stall_in_ready", 32'(in_ready[0]), 0);
      chk("stall_hold", cur(0), 32'(e));
      @(posedge clk); #1;
    end
    out_ready[0] = 1'b1;
    wait_idle(0);

    // reset-to-zero mode
    beat(1, 0, 100, 1);
    wait_idle(1);
    beat(1, 0, 0, 1);
    wait_idle(1);

    // out-of-range id: discarded, err sticky, eot still honoured
    beat(2, 3, 50, 0);
    chk("err_set", 32'(err[2]), 1);
    beat(2, 3, 5, 1);
    wait_idle(2);
    chk("err_sticky", 32'(err[2]), 1);

    // reset during the id1 result
    beat(2, 1, 100, 1);
    @(posedge clk); #1;
    chk("pre_rst_id", 32'(out_id[2]), 1);
    rst[2] = 1'b1;
    sb[2].delete();
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid[2]), 0);
    chk("post_rst_err", 32'(err[2]), 0);
    chk("post_rst_ts", 32'(out_ts[2]), 0);
    chk("post_rst_ready", 32'(in_ready[2]), 1);
    rst[2] = 1'b0;
    tsm[2] = 0;
    for (int i = 0; i < 4; i++) m[2][i] = 0;
    beat(2, 0, 0, 1);
    wait_idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
